// File: rtl/cond_flag_if.sv
// Condition-flag bus between the EX/WB flag writers, the branch decoder and cond_flag_unit.
interface cond_flag_if #(
  parameter int unsigned DATA_W = 36
);
  logic              fl_issue;
  logic              fl_wb_valid;
  logic [DATA_W-1:0] fl_wb_result;
  logic              flush;
  logic              br_req;
  logic              br_ack;
  logic              nz;
  logic              ez;
  logic              lz;
  logic              gz;
  logic              le;
  logic              ge;
  logic              fl_full;
  logic              fl_err;

  modport master (
    output fl_issue, fl_wb_valid, fl_wb_result, flush, br_req,
    input  br_ack, nz, ez, lz, gz, le, ge, fl_full, fl_err
  );

  modport slave (
    input  fl_issue, fl_wb_valid, fl_wb_result, flush, br_req,
    output br_ack, nz, ez, lz, gz, le, ge, fl_full, fl_err
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural condition flags with in-flight writer tracking, flush squashing
// and same-cycle writeback bypass to the branch stage.
module cond_flag_unit #(
  parameter int unsigned DATA_W      = 36,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  cond_flag_if.slave  cf
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  typedef enum logic {ST_READY, ST_WAIT} state_e;

  // Flag vector order: {nz, ez, lz, gz, le, ge}
  localparam logic [5:0] FLAGS_RST = 6'b010011;

  function automatic logic [5:0] flag_fn(input logic [DATA_W-1:0] r);
    logic ez_v;
    logic lz_v;
    ez_v = ~|r;
    lz_v = r[DATA_W-1];
    return {~ez_v, ez_v, lz_v, ~lz_v & ~ez_v, lz_v | ez_v, ~lz_v};
  endfunction

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [5:0]       flags_q, flags_d;
  logic             err_q, err_d;

  state_e           state_c;
  logic             live_wb_c;
  logic             disc_wb_c;
  logic             spur_wb_c;
  logic             full_c;
  logic             iss_ok_c;
  logic             drop_c;
  logic             ack_c;
  logic             bypass_c;
  logic [CNT_W:0]   disc_sum_c;
  logic [5:0]       flags_out_c;

  // Writeback routing and issue acceptance
  always_comb begin
    state_c    = (pend_q == '0) ? ST_READY : ST_WAIT;
    full_c     = (pend_q == CNT_W'(MAX_PENDING));
    disc_wb_c  = cf.fl_wb_valid & (disc_q != '0);
    live_wb_c  = cf.fl_wb_valid & (disc_q == '0) & (state_c == ST_WAIT);
    spur_wb_c  = cf.fl_wb_valid & (disc_q == '0) & (state_c == ST_READY);
    iss_ok_c   = cf.fl_issue & (~full_c | live_wb_c);
    drop_c     = cf.fl_issue & full_c & ~live_wb_c & ~cf.flush;
    // Squashed writers still in flight: the live wb of this cycle is not one of them
    disc_sum_c = (CNT_W+1)'(disc_q) - (CNT_W+1)'(disc_wb_c)
               + (CNT_W+1)'(pend_q) - (CNT_W+1)'(live_wb_c);
  end

  // Next-state for counters, flag register and sticky error
  always_comb begin
    pend_d  = pend_q;
    disc_d  = disc_q;
    flags_d = flags_q;
    err_d   = err_q;
    if (cf.flush) begin
      disc_d = (disc_sum_c > (CNT_W+1)'(MAX_PENDING)) ? CNT_W'(MAX_PENDING)
                                                      : CNT_W'(disc_sum_c);
      pend_d = CNT_W'(cf.fl_issue);
    end else begin
      if (disc_wb_c) disc_d = disc_q - CNT_W'(1);
      pend_d = pend_q + CNT_W'(iss_ok_c) - CNT_W'(live_wb_c);
    end
    if (live_wb_c) flags_d = flag_fn(cf.fl_wb_result);
    if (spur_wb_c | drop_c) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      disc_q  <= '0;
      flags_q <= FLAGS_RST;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      disc_q  <= disc_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // A same-cycle issue is a newer writer ahead of the branch, so it blocks the ack
  always_comb begin
    ack_c       = cf.br_req & ~cf.fl_issue &
                  ((state_c == ST_READY) |
                   ((pend_q == CNT_W'(1)) & cf.fl_wb_valid & (disc_q == '0)));
    bypass_c    = ack_c & (state_c == ST_WAIT);
    flags_out_c = bypass_c ? flag_fn(cf.fl_wb_result) : flags_q;
  end

  assign cf.br_ack  = ack_c;
  assign cf.nz      = flags_out_c[5];
  assign cf.ez      = flags_out_c[4];
  assign cf.lz      = flags_out_c[3];
  assign cf.gz      = flags_out_c[2];
  assign cf.le      = flags_out_c[1];
  assign cf.ge      = flags_out_c[0];
  assign cf.fl_full = full_c;
  assign cf.fl_err  = err_q;

endmodule
